// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: default width,
// FSM state encoding and iteration counter sizing.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // The counter must be able to hold WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder, try the subtract, keep it only when it does not borrow.
module div_step #(
    parameter int WIDTH = div_pkg::DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic             in_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   next_rem,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           borrow;

    // The remainder is always below the divisor, so its top bit stays zero.
    logic unused_rem_msb;
    assign unused_rem_msb = rem[WIDTH];

    always_comb begin
        shifted = {rem[WIDTH-1:0], in_bit};
        diff    = shifted - {1'b0, divisor};
        borrow  = diff[WIDTH];
        if (borrow) begin
            next_rem = shifted;
            q_bit    = 1'b0;
        end else begin
            next_rem = diff;
            q_bit    = 1'b1;
        end
    end

endmodule

// File: rtl/seq_divider32.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional feature macro: DIV_ZERO_FAST_EN (zero divisor finishes in one cycle).
module seq_divider32
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    div_state_t       state;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [WIDTH:0]   r;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   r_next;
    logic             q_bit;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem     (r),
        .in_bit  (q[WIDTH-1]),
        .divisor (d),
        .next_rem(r_next),
        .q_bit   (q_bit)
    );

`ifdef DIV_ZERO_FAST_EN
    logic zero_flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            q         <= '0;
            d         <= '0;
            r         <= '0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            zero_flag <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        d <= divisor;
                        // A zero divisor already knows its answer: all ones, remainder = dividend.
                        if (divisor == '0) begin
                            q         <= '1;
                            r         <= {1'b0, dividend};
                            count     <= '0;
                            zero_flag <= 1'b1;
                            state     <= DONE;
                        end else begin
                            q         <= dividend;
                            r         <= '0;
                            count     <= CNT_W'(WIDTH);
                            zero_flag <= 1'b0;
                            busy      <= 1'b1;
                            state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    r     <= r_next;
                    q     <= {q[WIDTH-2:0], q_bit};
                    count <= count - 1'b1;
                    if (count == CNT_W'(1)) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done      <= 1'b1;
                    quotient  <= q;
                    remainder <= r[WIDTH-1:0];
                    div_zero  <= zero_flag;
                    state     <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
`else
    assign div_zero = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            q         <= '0;
            d         <= '0;
            r         <= '0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        q     <= dividend;
                        d     <= divisor;
                        r     <= '0;
                        count <= CNT_W'(WIDTH);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    r     <= r_next;
                    q     <= {q[WIDTH-2:0], q_bit};
                    count <= count - 1'b1;
                    if (count == CNT_W'(1)) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done      <= 1'b1;
                    quotient  <= q;
                    remainder <= r[WIDTH-1:0];
                    state     <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_seq_divider32.sv
// Self-checking bench for seq_divider32: a timing/arithmetic model checked
// every cycle, plus directed operations with hand-computed results.
module tb_seq_divider32;

    localparam int W = 32;
`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
    logic          busy;
    logic          done;
    logic [W-1:0]  quotient;
    logic [W-1:0]  remainder;
    logic          div_zero;

    int checks = 0;
    int errors = 0;

    seq_divider32 #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted operation finishes lat cycles later with
    // plain-arithmetic results; phase counts edges since acceptance.
    bit           active = 1'b0;
    bit           pend_fast = 1'b0;
    int           phase = 0;
    int           lat = 0;
    logic [W-1:0] pend_q = '0, pend_r = '0;
    bit           pend_z = 1'b0;
    logic [W-1:0] exp_q = '0, exp_r = '0;
    bit           exp_z = 1'b0;

    always @(posedge clk or posedge rst) begin
        bit acc;
        if (rst) begin
            active <= 1'b0;
            pend_fast <= 1'b0;
            phase  <= 0;
            lat    <= 0;
            exp_q  <= '0;
            exp_r  <= '0;
            exp_z  <= 1'b0;
        end else begin
            acc = (start === 1'b1) && (!active || phase == lat);
            if (active && phase + 1 == lat) begin
                exp_q <= pend_q;
                exp_r <= pend_r;
                exp_z <= pend_z;
            end
            if (acc) begin
                active    <= 1'b1;
                phase     <= 0;
                pend_fast <= FAST && (divisor == 0);
                lat       <= (FAST && divisor == 0) ? 1 : W + 1;
                pend_q    <= (divisor == 0) ? '1 : dividend / divisor;
                pend_r    <= (divisor == 0) ? dividend : dividend % divisor;
                pend_z    <= FAST && (divisor == 0);
            end else if (active && phase == lat) begin
                active <= 1'b0;
            end else if (active) begin
                phase <= phase + 1;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("cyc_busy", 64'(busy), 64'(active && !pend_fast && phase < W));
        checkOutput("cyc_done", 64'(done), 64'(active && phase == lat));
        checkOutput("cyc_quot", 64'(quotient), 64'(exp_q));
        checkOutput("cyc_rem", 64'(remainder), 64'(exp_r));
        checkOutput("cyc_dz", 64'(div_zero), 64'(exp_z));
    end

    task automatic waitDone(output int idx, output int bcnt);
        idx = 0;
        bcnt = 0;
        while (done !== 1'b1 && idx < 100) begin
            bcnt += (busy === 1'b1) ? 1 : 0;
            @(negedge clk);
            idx++;
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input string name,
                                 input logic [W-1:0] eq, input logic [W-1:0] er, input bit ez,
                                 input int elat, input int ebusy);
        int idx, bcnt;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(idx, bcnt);
        checkOutput({name, "_lat"}, 64'(idx), 64'(elat));
        checkOutput({name, "_busy"}, 64'(bcnt), 64'(ebusy));
        checkOutput({name, "_quot"}, 64'(quotient), 64'(eq));
        checkOutput({name, "_rem"}, 64'(remainder), 64'(er));
        checkOutput({name, "_dz"}, 64'(div_zero), 64'(ez));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int idx, bcnt, ndone, first, second;
        logic [W-1:0] q1, r1, q2, r2;

        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_vals", {29'd0, busy, done, div_zero, quotient}, 64'd0);
        checkOutput("rst_rem", 64'(remainder), 64'd0);
        #1 rst = 1'b0;

        applyStimulus(32'd100, 32'd7, "d100_7", 32'd14, 32'd2, 1'b0, 33, 32);
        applyStimulus(32'hFFFF_FFFF, 32'd1, "dmax_1", 32'hFFFF_FFFF, 32'd0, 1'b0, 33, 32);
        applyStimulus(32'd5, 32'd10, "d5_10", 32'd0, 32'd5, 1'b0, 33, 32);
        applyStimulus(32'd12, 32'd0, "d12_0", 32'hFFFF_FFFF, 32'd12, FAST, FAST ? 1 : 33, FAST ? 0 : 32);

        // A second start during RUN must be ignored.
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        dividend = 32'd50;
        divisor  = 32'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(idx, bcnt);
        checkOutput("ign_lat", 64'(idx), 64'd22);
        checkOutput("ign_quot", 64'(quotient), 64'd14);
        checkOutput("ign_rem", 64'(remainder), 64'd2);
        ndone = 1;
        repeat (60) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        checkOutput("ign_pulses", 64'(ndone), 64'd1);

        // Asynchronous reset in the middle of RUN aborts without a done.
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("abort_vals", {29'd0, busy, done, div_zero, quotient}, 64'd0);
        checkOutput("abort_rem", 64'(remainder), 64'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        checkOutput("abort_nodone", 64'(ndone), 64'd0);
        applyStimulus(32'd9, 32'd4, "d9_4", 32'd2, 32'd1, 1'b0, 33, 32);

        // start held high: the second operation is accepted as soon as IDLE returns.
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(negedge clk);
        dividend = 32'h8000_0000;
        divisor  = 32'h10;
        idx = 0;
        first = -1;
        second = -1;
        q1 = '0; r1 = '0; q2 = '0; r2 = '0;
        while (second < 0 && idx < 200) begin
            if (done === 1'b1) begin
                if (first < 0) begin
                    first = idx;
                    q1 = quotient;
                    r1 = remainder;
                end else begin
                    second = idx;
                    q2 = quotient;
                    r2 = remainder;
                end
            end
            if (second < 0) begin
                @(negedge clk);
                idx++;
            end
        end
        start = 1'b0;
        checkOutput("b2b_first", 64'(first), 64'd33);
        checkOutput("b2b_gap", 64'(second - first), 64'd34);
        checkOutput("b2b_q1", 64'(q1), 64'd14);
        checkOutput("b2b_r1", 64'(r1), 64'd2);
        checkOutput("b2b_q2", 64'(q2), 64'h0800_0000);
        checkOutput("b2b_r2", 64'(r2), 64'd0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
